// File: rtl/axil_arb_2to1.sv
// Two-master AXI4-Lite arbiter in front of the ASR_rcv register slave.
// One whole write (AW+W+B) or read (AR+R) is granted at a time, round-robin between S0 and S1.
module axil_arb_2to1 #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,

  input  logic [C_ADDR_WIDTH-1:0]     S0_AXI_AWADDR,
  input  logic [2:0]                  S0_AXI_AWPROT,
  input  logic                        S0_AXI_AWVALID,
  output logic                        S0_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]     S0_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]   S0_AXI_WSTRB,
  input  logic                        S0_AXI_WVALID,
  output logic                        S0_AXI_WREADY,
  output logic [1:0]                  S0_AXI_BRESP,
  output logic                        S0_AXI_BVALID,
  input  logic                        S0_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]     S0_AXI_ARADDR,
  input  logic [2:0]                  S0_AXI_ARPROT,
  input  logic                        S0_AXI_ARVALID,
  output logic                        S0_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]     S0_AXI_RDATA,
  output logic [1:0]                  S0_AXI_RRESP,
  output logic                        S0_AXI_RVALID,
  input  logic                        S0_AXI_RREADY,

  input  logic [C_ADDR_WIDTH-1:0]     S1_AXI_AWADDR,
  input  logic [2:0]                  S1_AXI_AWPROT,
  input  logic                        S1_AXI_AWVALID,
  output logic                        S1_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]     S1_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]   S1_AXI_WSTRB,
  input  logic                        S1_AXI_WVALID,
  output logic                        S1_AXI_WREADY,
  output logic [1:0]                  S1_AXI_BRESP,
  output logic                        S1_AXI_BVALID,
  input  logic                        S1_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]     S1_AXI_ARADDR,
  input  logic [2:0]                  S1_AXI_ARPROT,
  input  logic                        S1_AXI_ARVALID,
  output logic                        S1_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]     S1_AXI_RDATA,
  output logic [1:0]                  S1_AXI_RRESP,
  output logic                        S1_AXI_RVALID,
  input  logic                        S1_AXI_RREADY,

  output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,

  output logic [1:0]                  GNT,
  output logic                        BUSY
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic sel;
  logic req0, req1, win, win_wr;
  logic aw_hs, w_hs;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Payload is muxed by the registered grant; gnt_q is 00 in IDLE so S0 is the idle default.
  assign sel = gnt_q[1];

  assign M_AXI_AWADDR = sel ? S1_AXI_AWADDR : S0_AXI_AWADDR;
  assign M_AXI_AWPROT = sel ? S1_AXI_AWPROT : S0_AXI_AWPROT;
  assign M_AXI_WDATA  = sel ? S1_AXI_WDATA  : S0_AXI_WDATA;
  assign M_AXI_WSTRB  = sel ? S1_AXI_WSTRB  : S0_AXI_WSTRB;
  assign M_AXI_ARADDR = sel ? S1_AXI_ARADDR : S0_AXI_ARADDR;
  assign M_AXI_ARPROT = sel ? S1_AXI_ARPROT : S0_AXI_ARPROT;

  assign sel_awvalid = sel ? S1_AXI_AWVALID : S0_AXI_AWVALID;
  assign sel_wvalid  = sel ? S1_AXI_WVALID  : S0_AXI_WVALID;
  assign sel_bready  = sel ? S1_AXI_BREADY  : S0_AXI_BREADY;
  assign sel_arvalid = sel ? S1_AXI_ARVALID : S0_AXI_ARVALID;
  assign sel_rready  = sel ? S1_AXI_RREADY  : S0_AXI_RREADY;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    aw_ready      = 1'b0;
    w_ready       = 1'b0;
    b_valid       = 1'b0;
    ar_ready      = 1'b0;
    r_valid       = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;

    req0   = S0_AXI_AWVALID | S0_AXI_ARVALID;
    req1   = S1_AXI_AWVALID | S1_AXI_ARVALID;
    win    = (req0 && req1) ? ~last_q : req1;
    win_wr = win ? S1_AXI_AWVALID : S0_AXI_AWVALID;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d     = win ? 2'b10 : 2'b01;
          last_d    = win;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = win_wr ? WR : RD_ADDR;
        end
      end
      // AW and W complete independently in any order; the done flags stop re-forwarding.
      WR: begin
        M_AXI_AWVALID = sel_awvalid & ~aw_done_q;
        aw_ready      = M_AXI_AWREADY & ~aw_done_q;
        M_AXI_WVALID  = sel_wvalid & ~w_done_q;
        w_ready       = M_AXI_WREADY & ~w_done_q;
        aw_hs         = M_AXI_AWVALID & M_AXI_AWREADY;
        w_hs          = M_AXI_WVALID & M_AXI_WREADY;
        aw_done_d     = aw_done_q | aw_hs;
        w_done_d      = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = sel_bready;
        b_valid      = M_AXI_BVALID;
        if (M_AXI_BVALID && sel_bready) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      RD_ADDR: begin
        M_AXI_ARVALID = sel_arvalid;
        ar_ready      = M_AXI_ARREADY;
        if (sel_arvalid && M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = sel_rready;
        r_valid      = M_AXI_RVALID;
        if (M_AXI_RVALID && sel_rready) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Handshake signals reach only the granted master; responses are broadcast unmodified.
  assign S0_AXI_AWREADY = aw_ready & gnt_q[0];
  assign S0_AXI_WREADY  = w_ready  & gnt_q[0];
  assign S0_AXI_BVALID  = b_valid  & gnt_q[0];
  assign S0_AXI_ARREADY = ar_ready & gnt_q[0];
  assign S0_AXI_RVALID  = r_valid  & gnt_q[0];
  assign S1_AXI_AWREADY = aw_ready & gnt_q[1];
  assign S1_AXI_WREADY  = w_ready  & gnt_q[1];
  assign S1_AXI_BVALID  = b_valid  & gnt_q[1];
  assign S1_AXI_ARREADY = ar_ready & gnt_q[1];
  assign S1_AXI_RVALID  = r_valid  & gnt_q[1];

  assign S0_AXI_BRESP = M_AXI_BRESP;
  assign S1_AXI_BRESP = M_AXI_BRESP;
  assign S0_AXI_RDATA = M_AXI_RDATA;
  assign S1_AXI_RDATA = M_AXI_RDATA;
  assign S0_AXI_RRESP = M_AXI_RRESP;
  assign S1_AXI_RRESP = M_AXI_RRESP;

  assign GNT  = gnt_q;
  assign BUSY = (state_q != IDLE);

endmodule
